// File: rtl/uram_burst_reader_if.sv
// Bundle of command, URAM read-port and return-stream signals for
// uram_burst_reader.
//   Command : start, base_addr, len -> busy, done
//   URAM    : mem_en, we, addr -> rdata
//   Stream  : m_valid, m_data, m_last -> m_ready
// master = the burst reader, slave = its environment (command source,
// URAM port and stream sink).
interface uram_burst_reader_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) ();
  logic              start;
  logic [AWIDTH-1:0] base_addr;
  logic [AWIDTH:0]   len;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;

  modport master (
    input  start, base_addr, len, rdata, m_ready,
    output busy, done, mem_en, we, addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, len, rdata, m_ready,
    input  busy, done, mem_en, we, addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/uram_burst_reader.sv
// Burst read initiator for one URAM port (read latency NBPIPE+1).
// A command (base_addr, len) is turned into len sequential reads; the
// returned words are buffered in a small FIFO and delivered on a
// valid/ready stream with m_last on the final word. Reads are only issued
// while FIFO entries + reads in flight < FIFO_DEPTH, so every returned word
// always has a slot and nothing is dropped under backpressure.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - uram_burst_reader_if.master (command, URAM port, stream)
module uram_burst_reader #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int NBPIPE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uram_burst_reader_if.master  bus
);
  localparam int LAT = NBPIPE + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1) + 1;
  localparam logic [AWIDTH:0] ONE = 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH:0]   remaining;
  logic [LAT-1:0]    vld_sr;
  logic [LAT-1:0]    tag_sr;
  logic              done_r;

  logic [DWIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic [CW-1:0] inflight;
  logic [CW-1:0] occupancy;
  logic          issue;
  logic          last_issue;
  logic          push;
  logic          pop;
  logic          m_valid_i;
  logic          m_last_i;

  // Credit is taken from registered counts only: a word popped this cycle
  // frees its slot for issue in the next cycle.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(vld_sr[i]);
    end
    occupancy  = fifo_count + inflight;
    issue      = (state == ISSUE) && (occupancy < CW'(FIFO_DEPTH));
    last_issue = issue && (remaining == ONE);
  end

  assign push      = vld_sr[LAT-1];
  assign m_valid_i = (fifo_count != '0);
  assign m_last_i  = m_valid_i & fifo_last[rd_ptr];
  assign pop       = m_valid_i & bus.m_ready;

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.mem_en  = issue;
  assign bus.we      = 1'b0;
  assign bus.addr    = cur_addr;
  assign bus.m_valid = m_valid_i;
  assign bus.m_last  = m_last_i;
  assign bus.m_data  = m_valid_i ? fifo_data[rd_ptr] : '0;

  // Command sequencing and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      vld_sr    <= '0;
      tag_sr    <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      vld_sr <= (vld_sr << 1) | LAT'(issue);
      tag_sr <= (tag_sr << 1) | LAT'(last_issue);
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              cur_addr  <= bus.base_addr;
              remaining <= bus.len;
              state     <= ISSUE;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            cur_addr  <= cur_addr + AWIDTH'(1);
            remaining <= remaining - ONE;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last_i) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return FIFO control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.rdata;
      fifo_last[wr_ptr] <= tag_sr[LAT-1];
    end
  end
endmodule

// File: tb/tb_uram_burst_reader.sv
// Self-checking bench for uram_burst_reader: two instances (NBPIPE=1 /
// FIFO_DEPTH=4 and NBPIPE=3 / FIFO_DEPTH=2), each fed by a behavioural URAM
// and checked against a word-level model of the expected stream.
module tb_uram_burst_reader;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uram_burst_reader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus0 ();
  uram_burst_reader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus1 ();

  uram_burst_reader #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(1), .FIFO_DEPTH(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uram_burst_reader #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(3), .FIFO_DEPTH(2))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic          start_s   [2];
  logic [AW-1:0] base_s    [2];
  logic [AW:0]   len_s     [2];
  logic          m_ready_s [2];
  logic [DW-1:0] rdata_s   [2];
  logic          busy_w [2], done_w [2], mem_en_w [2], we_w [2];
  logic          m_valid_w [2], m_last_w [2];
  logic [AW-1:0] addr_w [2];
  logic [DW-1:0] m_data_w [2];

  assign bus0.start = start_s[0];  assign bus1.start = start_s[1];
  assign bus0.base_addr = base_s[0]; assign bus1.base_addr = base_s[1];
  assign bus0.len = len_s[0];      assign bus1.len = len_s[1];
  assign bus0.m_ready = m_ready_s[0]; assign bus1.m_ready = m_ready_s[1];
  assign bus0.rdata = rdata_s[0];  assign bus1.rdata = rdata_s[1];
  assign busy_w[0] = bus0.busy;    assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus0.done;    assign done_w[1] = bus1.done;
  assign mem_en_w[0] = bus0.mem_en; assign mem_en_w[1] = bus1.mem_en;
  assign we_w[0] = bus0.we;        assign we_w[1] = bus1.we;
  assign addr_w[0] = bus0.addr;    assign addr_w[1] = bus1.addr;
  assign m_valid_w[0] = bus0.m_valid; assign m_valid_w[1] = bus1.m_valid;
  assign m_data_w[0] = bus0.m_data; assign m_data_w[1] = bus1.m_data;
  assign m_last_w[0] = bus0.m_last; assign m_last_w[1] = bus1.m_last;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic int fd_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  // Behavioural URAM contents and read pipelines (latency 2 and 4).
  logic [DW-1:0] mem_model [4096];
  logic [DW-1:0] pipe0 [2];
  logic [DW-1:0] pipe1 [4];
  always @(posedge clk) begin
    if (mem_en_w[0]) pipe0[0] <= mem_model[addr_w[0]];
    pipe0[1] <= pipe0[0];
    if (mem_en_w[1]) pipe1[0] <= mem_model[addr_w[1]];
    for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
  end
  assign rdata_s[0] = pipe0[1];
  assign rdata_s[1] = pipe1[3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected stream per instance: {last, data}.
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  function automatic void push_exp(input int k, input logic [32:0] v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic logic [32:0] pop_exp(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction
  function automatic int exp_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic void flush_exp(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  // Command bookkeeping written by the stimulus side.
  int cmd_seq [2] = '{0, 0};
  int cmd_base [2];
  int cmd_cyc [2];
  int exp_done [2] = '{0, 0};
  int rdy_mode [2] = '{0, 0};

  // Monitor-owned state.
  int seen_seq [2] = '{0, 0};
  int exp_addr [2], issued [2], popped [2];
  int en_cnt [2], first_en [2], last_en [2];
  int v_cnt [2], first_v [2], last_v [2], hs_cnt [2];
  int done_cnt [2] = '{0, 0};
  logic          prev_stall [2] = '{1'b0, 1'b0};
  logic [DW-1:0] prev_data [2];
  logic          prev_last [2];
  logic [4:0]    hist1 = '0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        flush_exp(k);
        issued[k] = 0;
        popped[k] = 0;
        prev_stall[k] = 1'b0;
        if (k == 1) hist1 = '0;
      end else begin
        int rel;
        logic [32:0] e;
        if (cmd_seq[k] != seen_seq[k]) begin
          seen_seq[k] = cmd_seq[k];
          exp_addr[k] = cmd_base[k];
          en_cnt[k] = 0; first_en[k] = -1; last_en[k] = -1;
          v_cnt[k] = 0;  first_v[k] = -1;  last_v[k] = -1;
          hs_cnt[k] = 0;
        end
        rel = cyc - cmd_cyc[k];
        if (mem_en_w[k]) begin
          check("read_addr", 64'(addr_w[k]), 64'(exp_addr[k]));
          check("we_low", 64'(we_w[k]), 64'd0);
          exp_addr[k] = (exp_addr[k] + 1) % 4096;
          issued[k]++;
          en_cnt[k]++;
          if (first_en[k] < 0) first_en[k] = rel;
          last_en[k] = rel;
          check("outstanding_le_depth", 64'((issued[k] - popped[k]) <= fd_of(k)), 64'd1);
        end
        if (k == 1) begin
          hist1 = {hist1[3:0], mem_en_w[1]};
          if (mem_en_w[1]) check("issue_duty_le_2", 64'($countones(hist1) <= 2), 64'd1);
        end
        if (prev_stall[k]) begin
          check("stall_valid_held", 64'(m_valid_w[k]), 64'd1);
          check("stall_data_held", 64'(m_data_w[k]), 64'(prev_data[k]));
          check("stall_last_held", 64'(m_last_w[k]), 64'(prev_last[k]));
        end
        if (m_valid_w[k]) begin
          v_cnt[k]++;
          if (first_v[k] < 0) first_v[k] = rel;
          last_v[k] = rel;
        end
        if (m_valid_w[k] && m_ready_s[k]) begin
          hs_cnt[k]++;
          popped[k]++;
          if (exp_size(k) == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = pop_exp(k);
            check("beat_data", 64'(m_data_w[k]), 64'(e[31:0]));
            check("beat_last", 64'(m_last_w[k]), 64'(e[32]));
          end
        end
        prev_stall[k] = m_valid_w[k] && !m_ready_s[k];
        prev_data[k]  = m_data_w[k];
        prev_last[k]  = m_last_w[k];
        if (done_w[k]) done_cnt[k]++;
      end
    end
  end

  // Sink readiness: 0 = always ready, 1 = ready 30% of cycles, 2 = stalled.
  initial begin
    m_ready_s[0] = 1'b1;
    m_ready_s[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rdy_mode[k])
          0:       m_ready_s[k] = 1'b1;
          1:       m_ready_s[k] = ($urandom_range(0, 9) < 3);
          default: m_ready_s[k] = 1'b0;
        endcase
      end
    end
  end

  // Called just after a rising edge; that cycle is cycle 0 of the command.
  task automatic issue_cmd(input int k, input int base, input int ln);
    logic [32:0] ent;
    cmd_base[k] = base;
    cmd_cyc[k]  = cyc;
    for (int i = 0; i < ln; i++) begin
      ent = {(i == ln - 1), mem_model[(base + i) % 4096]};
      push_exp(k, ent);
    end
    exp_done[k]++;
    start_s[k] = 1'b1;
    base_s[k]  = AW'(base);
    len_s[k]   = (AW + 1)'(ln);
    cmd_seq[k]++;
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int rel);
    int n;
    n = 0;
    rel = -1;
    while (n < budget) begin
      if (done_w[k]) begin
        rel = cyc - cmd_cyc[k];
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (rel < 0) check("done_timeout", 64'd0, 64'd1);
    else check("stream_drained_at_done", 64'(exp_size(k)), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},    64'(busy_w[0]),    64'd0);
    check({pfx, "_done"},    64'(done_w[0]),    64'd0);
    check({pfx, "_mem_en"},  64'(mem_en_w[0]),  64'd0);
    check({pfx, "_we"},      64'(we_w[0]),      64'd0);
    check({pfx, "_addr"},    64'(addr_w[0]),    64'd0);
    check({pfx, "_m_valid"}, 64'(m_valid_w[0]), 64'd0);
    check({pfx, "_m_data"},  64'(m_data_w[0]),  64'd0);
    check({pfx, "_m_last"},  64'(m_last_w[0]),  64'd0);
  endtask

  task automatic run_random(input int k, input int ncmd);
    int rel, ln, mode;
    for (int i = 0; i < ncmd; i++) begin
      mode = $urandom_range(0, 1);
      rdy_mode[k] = mode;
      ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      issue_cmd(k, $urandom_range(0, 4095), ln);
      wait_done(k, 1000, rel);
      if (ln == 0) check("rnd_len0_done", 64'(rel), 64'd1);
      else if (k == 0 && mode == 0) check("rnd_full_rate_done", 64'(rel), 64'(ln + 4));
      else check("rnd_done_not_early", 64'(rel >= ln + lat_of(k) + 2), 64'd1);
    end
    rdy_mode[k] = 0;
  endtask

  initial begin
    int rel;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      base_s[k]  = '0;
      len_s[k]   = '0;
    end
    for (int i = 0; i < 4096; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 8; i++) mem_model[16 + i] = 32'hA0 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    idle(2);

    // Directed burst with cycle-exact timing.
    issue_cmd(0, 'h010, 8);
    wait_done(0, 100, rel);
    check("t1_done_cycle", 64'(rel), 64'd12);
    check("t1_first_mem_en", 64'(first_en[0]), 64'd1);
    check("t1_last_mem_en", 64'(last_en[0]), 64'd8);
    check("t1_mem_en_count", 64'(en_cnt[0]), 64'd8);
    check("t1_first_valid", 64'(first_v[0]), 64'd4);
    check("t1_last_valid", 64'(last_v[0]), 64'd11);
    check("t1_beats", 64'(hs_cnt[0]), 64'd8);
    check("t1_busy_low_at_done", 64'(busy_w[0]), 64'd0);

    // Address wrap at the top of the URAM.
    idle(1);
    issue_cmd(0, 'hFFE, 4);
    wait_done(0, 100, rel);
    check("t2_beats", 64'(hs_cnt[0]), 64'd4);

    // Zero-length command: immediate done, no traffic.
    idle(1);
    issue_cmd(0, 'h055, 0);
    wait_done(0, 20, rel);
    check("t3_len0_done_cycle", 64'(rel), 64'd1);
    idle(5);
    check("t3_len0_no_mem_en", 64'(en_cnt[0]), 64'd0);
    check("t3_len0_no_valid", 64'(v_cnt[0]), 64'd0);

    // A second start while busy must be ignored.
    issue_cmd(0, 'h300, 8);
    idle(2);
    start_s[0] = 1'b1; base_s[0] = 12'h200; len_s[0] = 13'd5;
    idle(1);
    start_s[0] = 1'b0;
    wait_done(0, 100, rel);
    idle(12);
    check("t4_single_done", 64'(done_cnt[0]), 64'(exp_done[0]));
    check("t4_beats", 64'(hs_cnt[0]), 64'd8);

    // Backpressure: random ready, then a long full stall.
    rdy_mode[0] = 1;
    issue_cmd(0, 'h400, 16);
    idle(12);
    rdy_mode[0] = 2;
    idle(20);
    rdy_mode[0] = 0;
    wait_done(0, 500, rel);
    check("t5_beats", 64'(hs_cnt[0]), 64'd16);

    // Reset in the middle of a burst.
    idle(1);
    issue_cmd(0, 'h500, 8);
    idle(5);
    rst_n = 1'b0;
    exp_done[0]--;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    issue_cmd(0, 'h100, 2);
    wait_done(0, 100, rel);
    check("t6_done_cycle", 64'(rel), 64'd6);
    idle(10);
    check("t6_beats", 64'(hs_cnt[0]), 64'd2);

    // Deep pipeline with a two-entry buffer.
    issue_cmd(1, 'h010, 8);
    wait_done(1, 300, rel);
    check("t7_beats", 64'(hs_cnt[1]), 64'd8);
    check("t7_has_gaps", 64'(rel > 8 + 4 + 2), 64'd1);

    // Randomised commands on both instances concurrently.
    idle(2);
    fork
      run_random(0, 15);
      run_random(1, 15);
    join
    idle(2);

    // Maximum length command.
    issue_cmd(0, 'h7AB, 4096);
    wait_done(0, 5000, rel);
    check("t9_maxlen_done_cycle", 64'(rel), 64'd4100);
    check("t9_maxlen_beats", 64'(hs_cnt[0]), 64'd4096);

    idle(10);
    check("done_count_inst0", 64'(done_cnt[0]), 64'(exp_done[0]));
    check("done_count_inst1", 64'(done_cnt[1]), 64'(exp_done[1]));
    check("no_leftover_inst0", 64'(exp_size(0)), 64'd0);
    check("no_leftover_inst1", 64'(exp_size(1)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uram_burst_reader.md
# uram_burst_reader

Burst read initiator for one port of a dual-port URAM instance (read latency NBPIPE+1). Accepts a base-address/length command, issues sequential reads on the URAM port, tracks in-flight reads through the fixed pipeline latency, and delivers the returned words on a valid/ready stream with backpressure. A credit scheme guarantees no returned word is ever dropped. It is the consumer-side counterpart to the blocks that write URAM contents.

## Interface

- AWIDTH, 12, URAM address width
- DWIDTH, 32, URAM data width
- NBPIPE, 1, URAM output pipeline registers; read latency LAT = NBPIPE+1
- FIFO_DEPTH, 4, return-buffer entries; legal minimum 2; FIFO_DEPTH ≥ NBPIPE+3 required for 1 word/cycle
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  AWIDTH  first read address
- len  in  AWIDTH+1  word count, 0..2^AWIDTH
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at command completion
- mem_en  out  1  URAM port enable (read strobe)
- we  out  1  URAM write enable, constant 0
- addr  out  AWIDTH  URAM address
- rdata  in  DWIDTH  URAM dout
- m_valid  out  1  stream data valid
- m_ready  in  1  stream sink ready
- m_data  out  DWIDTH  stream data
- m_last  out  1  high with final word of the command

## Operation

- States: IDLE, ISSUE, DRAIN.
- IDLE: start=1 and len≠0 → latch base_addr, len; go ISSUE; busy=1 next cycle. start=1 and len=0 → done pulse next cycle, stay IDLE, no reads. start ignored outside IDLE.
- ISSUE: mem_en=1 with addr=current address when credit>0; credit = FIFO_DEPTH − fifo_count − inflight_count (registered values; a pop in the same cycle does not free credit until next cycle). Each issue: address +1 modulo 2^AWIDTH (wraps, no error), remaining −1. Issue of last word → DRAIN.
- In-flight tracking: LAT-deep valid shift register plus last-tag bit; entry reaching tail pushes rdata (sampled that cycle) and tag into FIFO. Overflow impossible by credit; bench asserts it.
- FIFO: first-word-fall-through to registered output; m_data/m_last/m_valid driven from head entry. Pop on m_valid & m_ready. m_data/m_last stable while m_valid & !m_ready.
- DRAIN: no issues; when final tagged word handshakes → done=1 next cycle, busy=0 same cycle as done, return to IDLE. New start accepted the cycle done is high.
- Reset: all state cleared asynchronously; in-flight reads discarded, FIFO emptied. Reset wins over simultaneous start.

## Timing

- Reset values: busy=0, done=0, mem_en=0, we=0, addr=0, m_valid=0, m_data=0, m_last=0.
- start accepted cycle 0 → first mem_en cycle 1 → rdata captured cycle 1+LAT → m_valid cycle 2+LAT (cycle 4 for NBPIPE=1).
- With m_ready=1 and FIFO_DEPTH ≥ NBPIPE+3: one mem_en and one beat per cycle, no gaps; len words complete in len+LAT+2 cycles from start to done.
- m_ready=0: issue stalls after credit exhausted; at most FIFO_DEPTH reads outstanding+buffered.
- done pulse exactly once per accepted command, one cycle after final handshake.

## Test plan

- Preload addr 0x010..0x017 = 0xA0..0xA7; start base=0x010 len=8, m_ready=1 → mem_en cycles 1–8, m_valid cycles 4–11, data 0xA0..0xA7, m_last at 0xA7, done cycle 12.
- Wrap: base=0xFFE len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order, 4 beats, m_last on 4th.
- Backpressure: len=16, m_ready random 30%, then held 0 for 20 cycles → no lost/duplicated words, outstanding+buffered never >4, data held stable while stalled.
- len=0 start → done at cycle 1, mem_en never asserted, m_valid stays 0; start while busy → ignored, only one done.
- Reset mid-burst: rst_n low at cycle 6 of len=8 → all outputs at reset values immediately; after release, new command base=0x100 len=2 returns only its 2 words, no stale data.
- NBPIPE=3, FIFO_DEPTH=2 → correct data for len=8 with gaps, mem_en duty ≤ 2 per LAT+1 window.
